// File: rtl/serial_logic_alu16_if.sv
// Start/done handshake bundle between the serial ALU and the register-file write stage.
// SERIAL_ALU_OVF_EN adds the signed-overflow flag to the bundle.
interface serial_logic_alu16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
`ifdef SERIAL_ALU_OVF_EN
    logic             ovf;

    modport master (output start, op, a, b,
                    input  busy, done, result, carry, zero, ovf);
    modport slave  (input  start, op, a, b,
                    output busy, done, result, carry, zero, ovf);
`else
    modport master (output start, op, a, b,
                    input  busy, done, result, carry, zero);
    modport slave  (input  start, op, a, b,
                    output busy, done, result, carry, zero);
`endif
endinterface

// File: rtl/serial_logic_alu16.sv
// Bit-serial XOR/AND/OR/ADD unit: one LSB-first bit pair per cycle, WIDTH cycles per op.
// Optional SERIAL_ALU_OVF_EN adds a signed-overflow flag for ADD.
module serial_logic_alu16 #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_logic_alu16_if.slave  bus
);
    localparam logic [1:0] OP_XOR = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
    logic [1:0]       op_q;
    logic [CNTW-1:0]  cnt;
    logic             c, c_nxt, r, last, capture;
    logic [WIDTH-1:0] result_q;
    logic             carry_q, zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        last      = (cnt == CNTW'(WIDTH - 1));
        capture   = bus.start && (state == IDLE || state == DONE);
        r         = 1'b0;
        c_nxt     = 1'b0;
        case (op_q)
            OP_XOR: r = a_sh[0] ^ b_sh[0];
            OP_AND: r = a_sh[0] & b_sh[0];
            OP_OR:  r = a_sh[0] | b_sh[0];
            OP_ADD: begin
                r     = a_sh[0] ^ b_sh[0] ^ c;
                c_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
            end
            default: r = 1'b0;
        endcase
        res_nxt = {r, res_sh[WIDTH-1:1]};
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Flags are loaded on the edge that processes the final bit, so they are
    // already valid during the DONE cycle alongside the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            op_q     <= '0;
            cnt      <= '0;
            c        <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else if (capture) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            op_q <= bus.op;
            cnt  <= '0;
            c    <= 1'b0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt;
            cnt    <= cnt + CNTW'(1);
            c      <= c_nxt;
            if (last) begin
                result_q <= res_nxt;
                carry_q  <= c_nxt;
                zero_q   <= (res_nxt == '0);
            end
        end
    end

`ifdef SERIAL_ALU_OVF_EN
    logic ovf_q;

    // c still holds the carry into the MSB while the final bit is processed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (!capture && state == RUN && last)
            ovf_q <= (op_q == OP_ADD) && (c ^ c_nxt);
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_logic_alu16.sv
// Directed bench for serial_logic_alu16: logic ops, ADD flags, ignored mid-run start,
// back-to-back start, and reset abort. Define SERIAL_ALU_OVF_EN to cover the ovf flag.
module tb_serial_logic_alu16;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [WIDTH-1:0] prev_res;

    serial_logic_alu16_if #(.WIDTH(WIDTH)) bus ();

    serial_logic_alu16 #(.WIDTH(WIDTH), .CNTW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Samples until done or budget; n = edges taken.
    task automatic wait_done(input int budget, output int n, output int busy_cnt);
        n = 0;
        busy_cnt = 0;
        while (!bus.done && n < budget) begin
            if (bus.busy) busy_cnt++;
            step();
            n++;
        end
    endtask

    task automatic check_flags(input string tag, input logic [WIDTH-1:0] res,
                               input logic cy, input logic zr, input logic ov);
        chk({tag, "_res"},   32'(bus.result), 32'(res));
        chk({tag, "_carry"}, 32'(bus.carry),  32'(cy));
        chk({tag, "_zero"},  32'(bus.zero),   32'(zr));
`ifdef SERIAL_ALU_OVF_EN
        chk({tag, "_ovf"},   32'(bus.ovf),    32'(ov));
`else
        if (ov === 1'bx) $display("unreachable");
`endif
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] res,
                          input logic cy, input logic zr, input logic ov);
        int n, bc;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        step();
        bus.start = 1'b0;
        bus.op = ~op; bus.a = ~a; bus.b = 16'h5A5A;
        chk({tag, "_hold"}, 32'(bus.result), 32'(prev_res));
        wait_done(40, n, bc);
        chk({tag, "_lat"},  32'(n),  32'(WIDTH));
        chk({tag, "_busy"}, 32'(bc), 32'(WIDTH));
        check_flags(tag, res, cy, zr, ov);
        prev_res = res;
        step();
        chk({tag, "_pulse"}, 32'(bus.done), 32'(0));
        chk({tag, "_idle"},  32'(bus.busy), 32'(0));
    endtask

    initial begin
        int n, bc, extra;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        prev_res = '0;
        #12;
        check_flags("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        rst_n = 1'b1;
        step();

        run_op("t1_xor",  2'b00, 16'hA5A5, 16'h0FF0, 16'hAA55, 1'b0, 1'b0, 1'b0);
        run_op("t2_xorz", 2'b00, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op("t3_addc", 2'b11, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("t4_addv", 2'b11, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1);
        run_op("t_and",   2'b01, 16'hFF00, 16'h0FF0, 16'h0F00, 1'b0, 1'b0, 1'b0);

        // Test 5: start pulsed mid-run must not disturb the OR in flight.
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 16'hF000; bus.b = 16'h000F;
        step();
        bus.start = 1'b0;
        repeat (5) step();
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 16'hF0F0; bus.b = 16'h3C3C;
        step();
        bus.start = 1'b0;
        chk("t5_busy_mid", 32'(bus.busy), 32'(1));
        wait_done(40, n, bc);
        chk("t5_lat", 32'(n + 6), 32'(WIDTH));
        check_flags("t5_or", 16'hF00F, 1'b0, 1'b0, 1'b0);
        // Back-to-back: start held during the DONE cycle.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t5_b2b_busy", 32'(bus.busy), 32'(1));
        chk("t5_b2b_hold", 32'(bus.result), 32'(16'hF00F));
        wait_done(40, n, bc);
        chk("t5_b2b_lat", 32'(n + 1), 32'(WIDTH + 1));
        check_flags("t5_b2b", 16'h3030, 1'b0, 1'b0, 1'b0);
        extra = 0;
        repeat (20) begin
            step();
            if (bus.done) extra++;
        end
        chk("t5_no_extra", 32'(extra), 32'(0));
        prev_res = 16'h3030;

        // Test 6: reset aborts an ADD mid-run.
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 16'hFFFF; bus.b = 16'h0001;
        step();
        bus.start = 1'b0;
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(bus.busy), 32'(0));
        chk("t6_done", 32'(bus.done), 32'(0));
        check_flags("t6", 16'h0000, 1'b0, 1'b0, 1'b0);
        extra = 0;
        repeat (2) begin
            step();
            if (bus.done) extra++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            step();
            if (bus.done || bus.busy) extra++;
        end
        chk("t6_no_done", 32'(extra), 32'(0));
        prev_res = 16'h0000;
        run_op("t6_after", 2'b01, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
